// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data_memory block: FSM state encoding,
// write/read arbitration grant, and the byte-address legality check.
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_RESP = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    // A byte address is legal when it is word aligned and every bit above
    // the word-index field is zero (no silent aliasing into the array).
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addr_bits);
        return (addr[1:0] == 2'b00) && ((addr >> (addr_bits + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store channel bundle between the requester (master) and data_memory
// (slave): an independent write channel and read channel, each with a
// valid/ready completion pulse and an error flag.
interface data_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [31:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_err;

    logic [31:0]           rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;
    logic                  rd_err;

    modport master (
        output wr_addr, wr_data, wr_strb, wr_valid, rd_addr, rd_valid,
        input  wr_ready, wr_err, rd_data, rd_ready, rd_err
    );

    modport slave (
        input  wr_addr, wr_data, wr_strb, wr_valid, rd_addr, rd_valid,
        output wr_ready, wr_err, rd_data, rd_ready, rd_err
    );
endinterface

// File: rtl/data_memory_array.sv
// Raw word storage: byte-strobed synchronous write and registered read with
// enable. No handshake and no reset; contents survive reset.
module data_memory_array #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_BITS-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  re_i,
    input  logic [ADDR_BITS-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Per-byte write merge and enabled read register.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory front end: single-outstanding FSM, fair
// write/read arbitration, address error reporting and a configurable read
// latency (1..4). Define DATA_MEMORY_STATS_EN to add write/read/error
// completion counters.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_BITS    = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic         clk,
    input  logic         reset,
    data_memory_if.slave bus
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [31:0]  stat_wr_count,
    output logic [31:0]  stat_rd_count,
    output logic [31:0]  stat_err_count
`endif
);
    // Wait cycles spent in RD_WAIT beyond the first, loaded on accept.
    localparam logic [1:0] CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    state_t                state_q;
    grant_t                last_grant_q;
    logic                  wr_ready_q, wr_err_q, rd_ready_q, rd_err_q;
    logic                  rd_zero_q, rd_err_pend_q;
    logic [1:0]            cnt_q;
    logic [ADDR_BITS-1:0]  rd_idx_q, rd_idx_d, wr_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_ok, rd_ok, acc_wr, acc_rd;
    logic                  rd_fire, rd_fire_err, mem_we, mem_re;
    logic [ADDR_BITS-1:0]  mem_raddr;

    assign wr_idx   = bus.wr_addr[ADDR_BITS+1:2];
    assign rd_idx_d = bus.rd_addr[ADDR_BITS+1:2];

    // Accept decision in IDLE; on a tie the channel not granted last time wins.
    always_comb begin
        acc_wr      = 1'b0;
        acc_rd      = 1'b0;
        wr_ok       = addr_ok(bus.wr_addr, ADDR_BITS);
        rd_ok       = addr_ok(bus.rd_addr, ADDR_BITS);
        if (state_q == IDLE) begin
            if (bus.wr_valid && bus.rd_valid) begin
                acc_wr = (last_grant_q == GRANT_RD);
                acc_rd = (last_grant_q == GRANT_WR);
            end else begin
                acc_wr = bus.wr_valid;
                acc_rd = bus.rd_valid;
            end
        end
        // Read response edge: the accept itself for latency 1, else the last wait edge.
        if (READ_LATENCY == 1) begin
            rd_fire     = acc_rd;
            rd_fire_err = !rd_ok;
            mem_raddr   = rd_idx_d;
        end else begin
            rd_fire     = (state_q == RD_WAIT) && (cnt_q == 2'd0);
            rd_fire_err = rd_err_pend_q;
            mem_raddr   = rd_idx_q;
        end
        mem_we = acc_wr && wr_ok && !reset;
        mem_re = rd_fire && !rd_fire_err && !reset;
    end

    data_memory_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_WIDTH(DATA_WIDTH),
        .STRB_WIDTH(STRB_WIDTH)
    ) u_array (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(wr_idx),
        .wdata_i(bus.wr_data),
        .wstrb_i(bus.wr_strb),
        .re_i   (mem_re),
        .raddr_i(mem_raddr),
        .rdata_o(mem_rdata)
    );

    // Control FSM with registered ready/err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_RD;
            wr_ready_q    <= 1'b0;
            wr_err_q      <= 1'b0;
            rd_ready_q    <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_zero_q     <= 1'b1;
            rd_err_pend_q <= 1'b0;
            cnt_q         <= 2'd0;
            rd_idx_q      <= '0;
        end else begin
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_ready_q <= 1'b0;
            rd_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acc_wr) begin
                        last_grant_q <= GRANT_WR;
                        wr_ready_q   <= 1'b1;
                        wr_err_q     <= !wr_ok;
                        state_q      <= WR_RESP;
                    end else if (acc_rd) begin
                        last_grant_q  <= GRANT_RD;
                        rd_idx_q      <= rd_idx_d;
                        rd_err_pend_q <= !rd_ok;
                        cnt_q         <= CNT_INIT;
                        state_q       <= (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 2'd0) state_q <= RD_RESP;
                    else               cnt_q   <= cnt_q - 2'd1;
                end
                default: state_q <= IDLE;
            endcase
            if (rd_fire) begin
                rd_ready_q <= 1'b1;
                rd_err_q   <= rd_fire_err;
                rd_zero_q  <= rd_fire_err;
            end
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.rd_ready = rd_ready_q;
    assign bus.rd_err   = rd_err_q;
    // Zero after reset and after an errored read; otherwise the last word read.
    assign bus.rd_data  = rd_zero_q ? '0 : mem_rdata;

`ifdef DATA_MEMORY_STATS_EN
    logic [31:0] stat_wr_q, stat_rd_q, stat_err_q;

    // Completion counters, bumped on the edge that raises each ready pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_wr_q  <= 32'd0;
            stat_rd_q  <= 32'd0;
            stat_err_q <= 32'd0;
        end else begin
            if (acc_wr)  stat_wr_q <= stat_wr_q + 32'd1;
            if (rd_fire) stat_rd_q <= stat_rd_q + 32'd1;
            if ((acc_wr && !wr_ok) || (rd_fire && rd_fire_err)) stat_err_q <= stat_err_q + 32'd1;
        end
    end

    assign stat_wr_count  = stat_wr_q;
    assign stat_rd_count  = stat_rd_q;
    assign stat_err_count = stat_err_q;
`endif
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: one latency-1 instance (dut) and one
// latency-3 instance (dut3), randomized traffic against an associative-array
// memory model, plus directed arbitration, error and reset scenarios.
module tb_data_memory;
    localparam int AB = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] model [int];
    logic [31:0] lat_word;

    data_memory_if #(.DATA_WIDTH(32)) m  ();
    data_memory_if #(.DATA_WIDTH(32)) m3 ();

`ifdef DATA_MEMORY_STATS_EN
    logic [31:0] s_wr, s_rd, s_err, s3_wr, s3_rd, s3_err;
`endif

    data_memory #(.ADDR_BITS(AB), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .bus(m)
`ifdef DATA_MEMORY_STATS_EN
        , .stat_wr_count(s_wr), .stat_rd_count(s_rd), .stat_err_count(s_err)
`endif
    );

    data_memory #(.ADDR_BITS(AB), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(m3)
`ifdef DATA_MEMORY_STATS_EN
        , .stat_wr_count(s3_wr), .stat_rd_count(s3_rd), .stat_err_count(s3_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic addr_good(input logic [31:0] a);
        return (a % 4 == 0) && (a < (32'd4 << AB));
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        logic [31:0] w;
        if (!addr_good(a)) return;
        k = int'(a >> 2);
        if (!model.exists(k)) begin
            if (s != 4'hF) return;
            w = 32'h0;
        end else begin
            w = model[k];
        end
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        model[k] = w;
    endfunction

    function automatic logic [31:0] gen_addr();
        logic [31:0] a;
        int k;
        a = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
        k = $urandom_range(0, 9);
        if (k == 8)      a = a + 32'($urandom_range(1, 3));
        else if (k == 9) a = a | (32'h1 << $urandom_range(18, 31));
        return a;
    endfunction

    task automatic do_write(input bit s3, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic err, output int lat);
        logic rdy;
        rdy = 1'b0; lat = 0; err = 1'b0;
        if (s3) begin m3.wr_addr = a; m3.wr_data = d; m3.wr_strb = s; m3.wr_valid = 1'b1; end
        else    begin m.wr_addr  = a; m.wr_data  = d; m.wr_strb  = s; m.wr_valid  = 1'b1; end
        while (!rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            rdy = s3 ? m3.wr_ready : m.wr_ready;
        end
        if (!rdy) begin n_cmp++; n_bad++; $display("FAIL wr_timeout addr=%h", a); end
        err = s3 ? m3.wr_err : m.wr_err;
        if (s3) m3.wr_valid = 1'b0; else m.wr_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input bit s3, input logic [31:0] a, output logic [31:0] d,
                           output logic err, output int lat);
        logic rdy;
        rdy = 1'b0; lat = 0; err = 1'b0; d = '0;
        if (s3) begin m3.rd_addr = a; m3.rd_valid = 1'b1; end
        else    begin m.rd_addr  = a; m.rd_valid  = 1'b1; end
        while (!rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            rdy = s3 ? m3.rd_ready : m.rd_ready;
        end
        if (!rdy) begin n_cmp++; n_bad++; $display("FAIL rd_timeout addr=%h", a); end
        d   = s3 ? m3.rd_data : m.rd_data;
        err = s3 ? m3.rd_err  : m.rd_err;
        if (s3) m3.rd_valid = 1'b0; else m.rd_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({m.wr_ready, m.wr_err, m.rd_ready, m.rd_err} !== 4'b0 || m.rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_dut got=%b/%h want=0000/0",
                     {m.wr_ready, m.wr_err, m.rd_ready, m.rd_err}, m.rd_data);
        end
        n_cmp++;
        if ({m3.wr_ready, m3.wr_err, m3.rd_ready, m3.rd_err} !== 4'b0 || m3.rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_dut3 got=%b/%h want=0000/0",
                     {m3.wr_ready, m3.wr_err, m3.rd_ready, m3.rd_err}, m3.rd_data);
        end
`ifdef DATA_MEMORY_STATS_EN
        n_cmp++;
        if (s_wr !== 32'd0 || s_rd !== 32'd0 || s_err !== 32'd0) begin
            n_bad++; $display("FAIL reset_stats got=%0d/%0d/%0d want=0/0/0", s_wr, s_rd, s_err);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic e; int lat; logic [31:0] d;
        do_write(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, e, lat);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        n_cmp++;
        if (e !== 1'b0 || lat != 1) begin n_bad++; $display("FAIL wr_full err=%b lat=%0d want 0/1", e, lat); end
        do_read(1'b0, 32'h10, d, e, lat);
        n_cmp++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || lat != 1) begin
            n_bad++; $display("FAIL rd_full got=%h/%b/%0d want=deadbeef/0/1", d, e, lat);
        end
`ifdef DATA_MEMORY_STATS_EN
        n_cmp++;
        if (s_wr !== 32'd1 || s_rd !== 32'd1 || s_err !== 32'd0) begin
            n_bad++; $display("FAIL stats_one got=%0d/%0d/%0d want=1/1/0", s_wr, s_rd, s_err);
        end
`endif
        do_write(1'b0, 32'h10, 32'h11223344, 4'h5, e, lat);
        model_write(32'h10, 32'h11223344, 4'h5);
        do_read(1'b0, 32'h10, d, e, lat);
        n_cmp++;
        if (d !== 32'hDE22BE44 || e !== 1'b0) begin
            n_bad++; $display("FAIL rd_strb got=%h/%b want=de22be44/0", d, e);
        end
    endtask

    task automatic test_errors();
        logic e; int lat; logic [31:0] d;
        do_read(1'b0, 32'h0004_0000, d, e, lat);
        n_cmp++;
        if (e !== 1'b1 || d !== 32'h0 || lat != 1) begin
            n_bad++; $display("FAIL rd_range got=%b/%h want=1/0", e, d);
        end
        do_write(1'b0, 32'h12, 32'hCAFEF00D, 4'hF, e, lat);
        n_cmp++;
        if (e !== 1'b1) begin n_bad++; $display("FAIL wr_align got=%b want=1", e); end
        do_write(1'b0, 32'h0004_0010, 32'h55AA55AA, 4'hF, e, lat);
        n_cmp++;
        if (e !== 1'b1) begin n_bad++; $display("FAIL wr_range got=%b want=1", e); end
        do_read(1'b0, 32'h10, d, e, lat);
        n_cmp++;
        if (d !== 32'hDE22BE44 || e !== 1'b0) begin
            n_bad++; $display("FAIL rd_unchanged got=%h/%b want=de22be44/0", d, e);
        end
    endtask

    task automatic test_random();
        logic e, good, chk; int lat; logic [31:0] a, d, exp; logic [3:0] s;
        for (int w = 0; w < 16; w++) begin
            a = 32'h100 + 32'(w) * 32'd4;
            d = $urandom;
            do_write(1'b0, a, d, 4'hF, e, lat);
            model_write(a, d, 4'hF);
        end
        for (int i = 0; i < 40; i++) begin
            a = gen_addr();
            good = addr_good(a);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(1'b0, a, d, s, e, lat);
                model_write(a, d, s);
                n_cmp++;
                if (e !== !good || lat != 1) begin
                    n_bad++; $display("FAIL rand_wr addr=%h err=%b lat=%0d want err=%b lat=1", a, e, lat, !good);
                end
            end else begin
                do_read(1'b0, a, d, e, lat);
                chk = 1'b1;
                exp = 32'h0;
                if (good) begin
                    if (model.exists(int'(a >> 2))) exp = model[int'(a >> 2)];
                    else chk = 1'b0;
                end
                n_cmp++;
                if (e !== !good || lat != 1 || (chk && d !== exp)) begin
                    n_bad++; $display("FAIL rand_rd addr=%h got=%h/%b want=%h/%b", a, d, e, exp, !good);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        string order;
        logic [31:0] last_w;
        bit prev;
        int bb, nresp;
        order = ""; prev = 0; bb = 0; nresp = 0; last_w = 32'h0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m.wr_addr = 32'h20; m.wr_data = $urandom; m.wr_strb = 4'hF; m.wr_valid = 1'b1;
        m.rd_addr = 32'h20; m.rd_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 8; c++) begin
            @(posedge clk); #1;
            if (m.wr_ready || m.rd_ready) begin
                if (prev || (m.wr_ready && m.rd_ready)) bb++;
                nresp++;
                if (m.wr_ready) begin
                    order = {order, "W"};
                    last_w = m.wr_data;
                    model_write(32'h20, last_w, 4'hF);
                    m.wr_data = $urandom;
                end else begin
                    order = {order, "R"};
                    n_cmp++;
                    if (m.rd_data !== last_w || m.rd_err !== 1'b0) begin
                        n_bad++; $display("FAIL arb_rd_data got=%h/%b want=%h/0", m.rd_data, m.rd_err, last_w);
                    end
                end
                prev = 1;
            end else begin
                prev = 0;
            end
        end
        m.wr_valid = 1'b0; m.rd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (order != "WRWRWRWR") begin n_bad++; $display("FAIL arb_order got=%s want=WRWRWRWR", order); end
        n_cmp++;
        if (bb != 0) begin n_bad++; $display("FAIL arb_spacing got=%0d adjacent pulses want=0", bb); end
    endtask

    task automatic test_reset_mid_write();
        logic e; int lat; logic [31:0] d, wd;
        wd = $urandom;
        m.wr_addr = 32'h30; m.wr_data = wd; m.wr_strb = 4'hF; m.wr_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (m.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rstw_ready got=%b want=1", m.wr_ready); end
        reset = 1'b1; m.wr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_write(32'h30, wd, 4'hF);
        do_read(1'b0, 32'h30, d, e, lat);
        n_cmp++;
        if (d !== wd || e !== 1'b0) begin n_bad++; $display("FAIL rstw_kept got=%h want=%h", d, wd); end
    endtask

    task automatic test_latency();
        logic e; int lat; logic [31:0] d;
        lat_word = $urandom;
        do_write(1'b1, 32'h40, lat_word, 4'hF, e, lat);
        n_cmp++;
        if (e !== 1'b0 || lat != 1) begin n_bad++; $display("FAIL l3_wr err=%b lat=%0d want 0/1", e, lat); end
        do_read(1'b1, 32'h40, d, e, lat);
        n_cmp++;
        if (d !== lat_word || e !== 1'b0 || lat != 3) begin
            n_bad++; $display("FAIL l3_rd got=%h/%b/%0d want=%h/0/3", d, e, lat, lat_word);
        end
        n_cmp++;
        if (m3.rd_ready !== 1'b0 || m3.rd_data !== lat_word) begin
            n_bad++; $display("FAIL l3_hold1 got=%b/%h want=0/%h", m3.rd_ready, m3.rd_data, lat_word);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (m3.rd_ready !== 1'b0 || m3.rd_data !== lat_word) begin
            n_bad++; $display("FAIL l3_hold2 got=%b/%h want=0/%h", m3.rd_ready, m3.rd_data, lat_word);
        end
        do_read(1'b1, 32'h41, d, e, lat);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b1 || lat != 3) begin
            n_bad++; $display("FAIL l3_err got=%h/%b/%0d want=0/1/3", d, e, lat);
        end
    endtask

    task automatic test_reset_mid_read();
        logic e; int lat; logic [31:0] d; bit seen;
        seen = 0;
        m3.rd_addr = 32'h40; m3.rd_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; m3.rd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({m3.wr_ready, m3.wr_err, m3.rd_ready, m3.rd_err} !== 4'b0 || m3.rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL rstr_outputs got=%b/%h want=0000/0",
                     {m3.wr_ready, m3.wr_err, m3.rd_ready, m3.rd_err}, m3.rd_data);
        end
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m3.rd_ready) seen = 1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL rstr_no_pulse got=1 want=0"); end
        do_read(1'b1, 32'h40, d, e, lat);
        n_cmp++;
        if (d !== lat_word || e !== 1'b0 || lat != 3) begin
            n_bad++; $display("FAIL rstr_after got=%h/%b/%0d want=%h/0/3", d, e, lat, lat_word);
        end
    endtask

    initial begin
        reset = 1'b1;
        m.wr_addr = '0;  m.wr_data = '0;  m.wr_strb = '0;  m.wr_valid = 1'b0;
        m.rd_addr = '0;  m.rd_valid = 1'b0;
        m3.wr_addr = '0; m3.wr_data = '0; m3.wr_strb = '0; m3.wr_valid = 1'b0;
        m3.rd_addr = '0; m3.rd_valid = 1'b0;
        lat_word = '0;
        test_reset();
        test_directed();
        test_errors();
        test_random();
        test_arbitration();
        test_reset_mid_write();
        test_latency();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
